// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous data-RAM port among the CPU MEM stage (read/write),
//   the debug console (read-only) and the seven-segment scanner (read-only).
//   The CPU has priority. Debug and scanner share the remaining slots
//   round-robin. Grants are combinational in the request cycle. Read data
//   returns one cycle later with a per-requester valid strobe.
//   Build option: define STARVE_GUARD_EN to build the anti-starvation counters.
//   With it, a low-priority master that has waited STARVE_LIMIT cycles takes
//   the port ahead of the CPU.
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    input  logic              scn_req,
    input  logic [ADDR_W-1:0] scn_addr,
    output logic              scn_gnt,
    output logic              scn_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic w_cpu_win;
    logic w_dbg_win;
    logic w_scn_win;
    logic w_rr_dbg;
    logic w_rr_scn;
    logic r_rr_last;
    logic r_cpu_rvalid;
    logic r_dbg_rvalid;
    logic r_scn_rvalid;

    // r_rr_last = 1 means the scanner went last, so debug takes a tie.
    assign w_rr_dbg = dbg_req && (!scn_req || r_rr_last);
    assign w_rr_scn = scn_req && !w_rr_dbg;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] r_dbg_wait;
    logic [WAIT_W-1:0] r_scn_wait;
    logic              w_dbg_starved;
    logic              w_scn_starved;

    assign w_dbg_starved = dbg_req && (r_dbg_wait == WAIT_MAX);
    assign w_scn_starved = scn_req && (r_scn_wait == WAIT_MAX);

    // Winner select: a saturated waiter beats the CPU; two saturated waiters use round-robin
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        w_scn_win = 1'b0;
        if (w_dbg_starved && w_scn_starved) begin
            w_dbg_win = r_rr_last;
            w_scn_win = !r_rr_last;
        end else if (w_dbg_starved) begin
            w_dbg_win = 1'b1;
        end else if (w_scn_starved) begin
            w_scn_win = 1'b1;
        end else if (cpu_req) begin
            w_cpu_win = 1'b1;
        end else begin
            w_dbg_win = w_rr_dbg;
            w_scn_win = w_rr_scn;
        end
    end

    // Wait counters: count ungranted request cycles, saturate, clear on grant or dropped request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_wait <= '0;
            r_scn_wait <= '0;
        end else begin
            if (!dbg_req || w_dbg_win) begin
                r_dbg_wait <= '0;
            end else if (r_dbg_wait != WAIT_MAX) begin
                r_dbg_wait <= r_dbg_wait + WAIT_W'(1);
            end
            if (!scn_req || w_scn_win) begin
                r_scn_wait <= '0;
            end else if (r_scn_wait != WAIT_MAX) begin
                r_scn_wait <= r_scn_wait + WAIT_W'(1);
            end
        end
    end
`else
    // Without the guard the CPU always wins and the others may starve.
    assign w_cpu_win = cpu_req;
    assign w_dbg_win = !cpu_req && w_rr_dbg;
    assign w_scn_win = !cpu_req && w_rr_scn;
`endif

    // RAM port mux: drive the winner's request, all zeros when idle
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_cpu_win) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (w_dbg_win) begin
            ram_en    = 1'b1;
            ram_addr  = dbg_addr;
        end else if (w_scn_win) begin
            ram_en    = 1'b1;
            ram_addr  = scn_addr;
        end
    end

    // Read-valid pipeline and round-robin history; reset drops any read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last    <= 1'b1;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_scn_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_win && !cpu_we;
            r_dbg_rvalid <= w_dbg_win;
            r_scn_rvalid <= w_scn_win;
            if (w_dbg_win) begin
                r_rr_last <= 1'b0;
            end else if (w_scn_win) begin
                r_rr_last <= 1'b1;
            end
        end
    end

    assign cpu_gnt    = w_cpu_win;
    assign dbg_gnt    = w_dbg_win;
    assign scn_gnt    = w_scn_win;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign scn_rvalid = r_scn_rvalid;
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 15;
    localparam int DEPTH        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              dbg_req = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic              scn_req = 1'b0;
    logic [ADDR_W-1:0] scn_addr = '0;
    logic              scn_gnt;
    logic              scn_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .scn_req   (scn_req),
        .scn_addr  (scn_addr),
        .scn_gnt   (scn_gnt),
        .scn_rvalid(scn_rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous RAM attached to the arbiter's port
    logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
    // Expected RAM contents, updated only from the model's own decisions
    logic [DATA_W-1:0] shadow  [0:DEPTH-1];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'hA500_0000 | DATA_W'(i);
            shadow[i]  = 32'hA500_0000 | DATA_W'(i);
        end
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             m_dbg_wait;
    int             m_scn_wait;
    bit             m_dbg_first;   // debug wins the next dbg/scn tie
    int             m_rv_owner;    // 0 none, 1 cpu, 2 dbg, 3 scn
    logic [DATA_W-1:0] m_rv_data;

    task automatic model_reset();
        m_dbg_wait  = 0;
        m_scn_wait  = 0;
        m_dbg_first = 1'b1;
        m_rv_owner  = 0;
    endtask

    initial begin : compare
        int                win;
        bit                dbg_st;
        bit                scn_st;
        logic [ADDR_W-1:0] ea;
        int                nxt_owner;
        logic [DATA_W-1:0] nxt_data;
        int                nxt_dw;
        int                nxt_sw;
        bit                nxt_first;
        bit                wr_pend;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            dbg_st = 1'b0;
            scn_st = 1'b0;
`ifdef STARVE_GUARD_EN
            dbg_st = dbg_req && (m_dbg_wait >= STARVE_LIMIT);
            scn_st = scn_req && (m_scn_wait >= STARVE_LIMIT);
`endif
            if (dbg_st && scn_st)         win = m_dbg_first ? 2 : 3;
            else if (dbg_st)              win = 2;
            else if (scn_st)              win = 3;
            else if (cpu_req)             win = 1;
            else if (dbg_req && scn_req)  win = m_dbg_first ? 2 : 3;
            else if (dbg_req)             win = 2;
            else if (scn_req)             win = 3;
            else                          win = 0;

            case (win)
                1:       ea = cpu_addr;
                2:       ea = dbg_addr;
                3:       ea = scn_addr;
                default: ea = '0;
            endcase

            check("cpu_gnt", cpu_gnt, win == 1);
            check("dbg_gnt", dbg_gnt, win == 2);
            check("scn_gnt", scn_gnt, win == 3);
            check("ram_en", ram_en, win != 0);
            check("ram_we", ram_we, (win == 1) && cpu_we);
            check("ram_addr", ram_addr, ea);
            if (win == 0) check("ram_wdata_idle", ram_wdata, 0);
            if (win == 1 && cpu_we) check("ram_wdata", ram_wdata, cpu_wdata);
            check("cpu_rvalid", cpu_rvalid, m_rv_owner == 1);
            check("dbg_rvalid", dbg_rvalid, m_rv_owner == 2);
            check("scn_rvalid", scn_rvalid, m_rv_owner == 3);
            if (m_rv_owner != 0) check("rdata", rdata, m_rv_data);

            nxt_owner = (win == 1) ? (cpu_we ? 0 : 1) : win;
            nxt_data  = shadow[ea];
            wr_pend   = (win == 1) && cpu_we;
            wr_addr   = cpu_addr;
            wr_data   = cpu_wdata;
            nxt_dw    = (dbg_req && win != 2) ? ((m_dbg_wait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_dbg_wait + 1) : 0;
            nxt_sw    = (scn_req && win != 3) ? ((m_scn_wait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_scn_wait + 1) : 0;
            nxt_first = (win == 2) ? 1'b0 : (win == 3) ? 1'b1 : m_dbg_first;

            @(posedge clk);
            if (wr_pend) shadow[wr_addr] = wr_data;
            if (!rst_n) begin
                model_reset();
            end else begin
                m_rv_owner  = nxt_owner;
                m_rv_data   = nxt_data;
                m_dbg_wait  = nxt_dw;
                m_scn_wait  = nxt_sw;
                m_dbg_first = nxt_first;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        scn_req = 1'b0; scn_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin : stim
        bit s_cpu, s_dbg, s_scn;
        int starve_cycle;
`ifdef STARVE_GUARD_EN
        starve_cycle = STARVE_LIMIT + 1;
`else
        starve_cycle = 0;
`endif
        do_reset();

        // 1: scanner alone
        scn_req = 1'b1; scn_addr = 10'h005;
        @(negedge clk);
        check("t1_scn_gnt", scn_gnt, 1);
        check("t1_ram_addr", ram_addr, 10'h005);
        tick(); scn_req = 1'b0;
        @(negedge clk);
        check("t1_scn_rvalid", scn_rvalid, 1);
        check("t1_rdata", rdata, 32'hA500_0005);
        tick();

        // 2: all three at once, CPU first then round-robin with debug first
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        dbg_req = 1'b1; dbg_addr = 10'h020;
        scn_req = 1'b1; scn_addr = 10'h030;
        @(negedge clk);
        check("t2_cpu_gnt", cpu_gnt, 1);
        check("t2_dbg_held", dbg_gnt, 0);
        check("t2_scn_held", scn_gnt, 0);
        tick(); cpu_req = 1'b0;
        @(negedge clk);
        check("t2_cpu_rvalid", cpu_rvalid, 1);
        check("t2_cpu_rdata", rdata, 32'hA500_0010);
        check("t2_dbg_gnt", dbg_gnt, 1);
        tick(); dbg_req = 1'b0;
        @(negedge clk);
        check("t2_scn_gnt", scn_gnt, 1);
        check("t2_dbg_rdata", rdata, 32'hA500_0020);
        tick(); scn_req = 1'b0;
        @(negedge clk);
        check("t2_scn_rdata", rdata, 32'hA500_0030);
        tick();

        // 3: debug and scanner held, grants alternate starting with debug
        do_reset();
        dbg_req = 1'b1; dbg_addr = 10'h040;
        scn_req = 1'b1; scn_addr = 10'h050;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t3_dbg_gnt", dbg_gnt, (k % 2) == 0);
            check("t3_scn_gnt", scn_gnt, (k % 2) == 1);
            tick();
        end
        idle();

        // 4: CPU write then read back
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t4_ram_we", ram_we, 1);
        check("t4_ram_addr", ram_addr, 10'h3FF);
        check("t4_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick(); idle();
        @(negedge clk);
        check("t4_no_rvalid", cpu_rvalid, 0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
        @(negedge clk);
        check("t4_rd_gnt", cpu_gnt, 1);
        tick(); idle();
        @(negedge clk);
        check("t4_rd_rvalid", cpu_rvalid, 1);
        check("t4_rd_data", rdata, 32'hDEAD_BEEF);
        tick();

        // 5: CPU held with debug waiting
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h100;
        dbg_req = 1'b1; dbg_addr = 10'h101;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("t5_cpu_gnt", cpu_gnt, c != starve_cycle);
            check("t5_dbg_gnt", dbg_gnt, c == starve_cycle);
            tick();
            if (c == starve_cycle) dbg_req = 1'b0;
        end
        idle();

        // 6: reset lands while a read is in flight
        do_reset();
        dbg_req = 1'b1; dbg_addr = 10'h007;
        @(negedge clk);
        check("t6_dbg_gnt", dbg_gnt, 1);
        tick(); dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h011;
        @(negedge clk);
        check("t6_cpu_gnt", cpu_gnt, 1);
        #2 rst_n = 1'b0;
        tick(); idle();
        @(negedge clk);
        check("t6_rvalid_in_rst", cpu_rvalid, 0);
        #2 rst_n = 1'b1;
        tick();
        dbg_req = 1'b1; dbg_addr = 10'h008;
        scn_req = 1'b1; scn_addr = 10'h009;
        @(negedge clk);
        check("t6_rvalid_after", cpu_rvalid, 0);
        check("t6_tie_dbg", dbg_gnt, 1);
        check("t6_tie_scn", scn_gnt, 0);
        tick(); idle();
        tick();

        // Random traffic: CPU-heavy first half, lighter second half
        do_reset();
        s_cpu = 1'b0; s_dbg = 1'b0; s_scn = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (cpu_req && !s_cpu) begin
                if ($urandom_range(0, 15) == 0) cpu_req = 1'b0;
            end else begin
                cpu_req   = (n < 1500) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = ADDR_W'($urandom);
                cpu_wdata = DATA_W'($urandom);
            end
            if (dbg_req && !s_dbg) begin
                if ($urandom_range(0, 31) == 0) dbg_req = 1'b0;
            end else begin
                dbg_req  = ($urandom_range(0, 1) == 0);
                dbg_addr = ADDR_W'($urandom);
            end
            if (scn_req && !s_scn) begin
                if ($urandom_range(0, 31) == 0) scn_req = 1'b0;
            end else begin
                scn_req  = ($urandom_range(0, 1) == 0);
                scn_addr = ADDR_W'($urandom);
            end
            @(negedge clk);
            s_cpu = cpu_gnt;
            s_dbg = dbg_gnt;
            s_scn = scn_gnt;
            tick();
        end
        idle();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
